reset_sequencer: RTL and testbench

- Sits directly downstream of the clock-generation MMCM and runs in one of its output clock domains (25.175 MHz pixel clock or 8 MHz CPU clock).
- Turns the MMCM's asynchronous LOCKED flag and a raw board reset button into clean, staged, synchronous reset releases.
- Video logic comes out of reset first; the CPU follows a fixed gap later.
- Any loss of lock, or a debounced button press, re-enters reset and counts lock-loss events for debug.

---
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer for the MMCM output clock domain.
// Synchronises the MMCM lock flag and the board reset button, debounces the
// button, and releases the video reset first and the CPU reset a fixed gap
// later. Lock losses seen while fully running are counted (saturating).
module reset_sequencer #(
   parameter int unsigned SYNC_STAGES      = 2,
   parameter int unsigned LOCK_HOLD_CYCLES = 1024,
   parameter int unsigned STAGE_GAP_CYCLES = 16,
   parameter int unsigned DEBOUNCE_CYCLES  = 65536
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       LOCKED,
   input  logic       BTN_RESET,
   output logic       RESET_VIDEO,
   output logic       RESET_CPU,
   output logic       READY,
   output logic [7:0] LOSS_COUNT
);

   localparam int unsigned CNT_MAX = (LOCK_HOLD_CYCLES > STAGE_GAP_CYCLES) ?
                                     LOCK_HOLD_CYCLES : STAGE_GAP_CYCLES;
   // A single-cycle hold and gap would give a zero-width counter; keep one bit.
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StWaitLock,
      StHold,
      StReleaseVideo,
      StRun
   } state_e;

   logic [SYNC_STAGES-1:0] locked_sync_q;
   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic                   locked_s;
   logic                   btn_s;

   logic                   btn_db_q;
   logic [DB_W-1:0]        db_cnt_q;

   logic                   fault;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;

   // Multi-flop synchronisers; nothing else touches LOCKED or BTN_RESET.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         locked_sync_q <= '0;
         btn_sync_q    <= '0;
      end else begin
         locked_sync_q <= {locked_sync_q[SYNC_STAGES-2:0], LOCKED};
         btn_sync_q    <= {btn_sync_q[SYNC_STAGES-2:0], BTN_RESET};
      end
   end

   assign locked_s = locked_sync_q[SYNC_STAGES-1];
   assign btn_s    = btn_sync_q[SYNC_STAGES-1];

   // Button debounce: follow btn_s only after it has disagreed for the full window.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         btn_db_q <= 1'b0;
         db_cnt_q <= '0;
      end else if (btn_s == btn_db_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         btn_db_q <= btn_s;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end

   assign fault = ~locked_s | btn_db_q;

   // Sequencer FSM; outputs are loaded alongside the state so they move on the same edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= StWaitLock;
         cnt_q       <= '0;
         RESET_VIDEO <= 1'b1;
         RESET_CPU   <= 1'b1;
         READY       <= 1'b0;
         LOSS_COUNT  <= 8'd0;
      end else begin
         unique case (state_q)
            StWaitLock: begin
               if (!fault) begin
                  state_q <= StHold;
                  cnt_q   <= '0;
               end
            end

            StHold: begin
               // Fault wins over hold completion.
               if (fault) begin
                  state_q <= StWaitLock;
                  cnt_q   <= '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_q     <= StReleaseVideo;
                  cnt_q       <= '0;
                  RESET_VIDEO <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            StReleaseVideo: begin
               if (fault) begin
                  state_q     <= StWaitLock;
                  cnt_q       <= '0;
                  RESET_VIDEO <= 1'b1;
               end else if (cnt_q == GAP_LAST) begin
                  state_q   <= StRun;
                  cnt_q     <= '0;
                  RESET_CPU <= 1'b0;
                  READY     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            StRun: begin
               if (fault) begin
                  state_q     <= StWaitLock;
                  cnt_q       <= '0;
                  RESET_VIDEO <= 1'b1;
                  RESET_CPU   <= 1'b1;
                  READY       <= 1'b0;
                  // Only lock loss is counted; a button press alone is not.
                  if (!locked_s && (LOSS_COUNT != 8'hFF)) begin
                     LOSS_COUNT <= LOSS_COUNT + 8'd1;
                  end
               end
            end

            default: begin
               state_q     <= StWaitLock;
               cnt_q       <= '0;
               RESET_VIDEO <= 1'b1;
               RESET_CPU   <= 1'b1;
               READY       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with a run-length based reference model.
module tb_reset_sequencer;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned HOLD  = 8;
   localparam int unsigned GAP   = 4;
   localparam int unsigned DEB   = 4;
   // Consecutive fault-free edges needed for each release.
   localparam int          VID_RUN = HOLD + 1;
   localparam int          CPU_RUN = HOLD + GAP + 1;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       LOCKED = 1'b0;
   logic       BTN_RESET = 1'b0;
   logic       RESET_VIDEO;
   logic       RESET_CPU;
   logic       READY;
   logic [7:0] LOSS_COUNT;

   int checks = 0;
   int passed = 0;

   reset_sequencer #(
      .SYNC_STAGES      (SYNC),
      .LOCK_HOLD_CYCLES (HOLD),
      .STAGE_GAP_CYCLES (GAP),
      .DEBOUNCE_CYCLES  (DEB)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .LOCKED      (LOCKED),
      .BTN_RESET   (BTN_RESET),
      .RESET_VIDEO (RESET_VIDEO),
      .RESET_CPU   (RESET_CPU),
      .READY       (READY),
      .LOSS_COUNT  (LOSS_COUNT)
   );

   always #5 CLK = ~CLK;

   // Reference model: history queues of raw samples, a debounce run length,
   // and the number of consecutive fault-free edges decide every output.
   bit lock_hist[$];
   bit btn_hist[$];
   bit m_db;
   int db_run;
   int good_run;
   int m_loss;

   task automatic model_reset();
      lock_hist.delete();
      btn_hist.delete();
      m_db     = 1'b0;
      db_run   = 0;
      good_run = 0;
      m_loss   = 0;
   endtask

   task automatic model_edge();
      bit ls;
      bit bs;
      bit f;
      ls = (lock_hist.size() >= SYNC) ? lock_hist[SYNC-1] : 1'b0;
      bs = (btn_hist.size() >= SYNC) ? btn_hist[SYNC-1] : 1'b0;
      f  = !ls || m_db;
      if (f && good_run >= CPU_RUN && !ls && m_loss < 255) m_loss++;
      if (f) good_run = 0;
      else if (good_run < 100000) good_run++;
      if (bs != m_db) begin
         db_run++;
         if (db_run == DEB) begin
            m_db   = bs;
            db_run = 0;
         end
      end else begin
         db_run = 0;
      end
      lock_hist.push_front(LOCKED);
      btn_hist.push_front(BTN_RESET);
      if (lock_hist.size() > SYNC) void'(lock_hist.pop_back());
      if (btn_hist.size() > SYNC) void'(btn_hist.pop_back());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or posedge RESET);
         if (RESET) model_reset();
         else model_edge();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         logic       e_rv;
         logic       e_cpu;
         logic       e_rdy;
         logic [7:0] e_loss;
         @(negedge CLK);
         e_rv   = (good_run < VID_RUN);
         e_rdy  = (good_run >= CPU_RUN);
         e_cpu  = !e_rdy;
         e_loss = 8'(m_loss);
         checks++;
         if (RESET_VIDEO === e_rv && RESET_CPU === e_cpu && READY === e_rdy &&
             LOSS_COUNT === e_loss) begin
            passed++;
         end else begin
            $display("FAIL model_cmp t=%0t: got rv=%b cpu=%b ready=%b loss=%0d, expected rv=%b cpu=%b ready=%b loss=%0d",
                     $time, RESET_VIDEO, RESET_CPU, READY, LOSS_COUNT, e_rv, e_cpu, e_rdy,
                     e_loss);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Called right after LOCKED becomes good (or RESET drops): edge 1 is the next edge.
   task automatic check_release(input string tag);
      repeat (10) step();
      chk({tag, "_rv_e10"}, int'(RESET_VIDEO), 1);
      step();
      chk({tag, "_rv_e11"}, int'(RESET_VIDEO), 0);
      chk({tag, "_cpu_e11"}, int'(RESET_CPU), 1);
      repeat (3) step();
      chk({tag, "_ready_e14"}, int'(READY), 0);
      step();
      chk({tag, "_ready_e15"}, int'(READY), 1);
      chk({tag, "_cpu_e15"}, int'(RESET_CPU), 0);
   endtask

   initial begin
      bit ok;
      int loss_before;

      // Power-up with LOCKED already high.
      LOCKED = 1'b1;
      repeat (3) step();
      chk("rst_rv", int'(RESET_VIDEO), 1);
      chk("rst_cpu", int'(RESET_CPU), 1);
      chk("rst_ready", int'(READY), 0);
      chk("rst_loss", int'(LOSS_COUNT), 0);
      RESET = 1'b0;
      check_release("pwrup");
      chk("pwrup_loss", int'(LOSS_COUNT), 0);

      // Lock loss in RUN: resets on the 3rd edge, then identical release timing.
      LOCKED = 1'b0;
      step();
      step();
      chk("loss_ready_e2", int'(READY), 1);
      step();
      chk("loss_ready_e3", int'(READY), 0);
      chk("loss_rv_e3", int'(RESET_VIDEO), 1);
      chk("loss_cpu_e3", int'(RESET_CPU), 1);
      chk("loss_count_1", int'(LOSS_COUNT), 1);
      LOCKED = 1'b1;
      check_release("relock");

      // Lock glitch while holding: the hold restarts from scratch.
      LOCKED = 1'b0;
      repeat (3) step();
      LOCKED = 1'b1;
      repeat (8) step();
      LOCKED = 1'b0;
      step();
      LOCKED = 1'b1;
      ok = 1'b1;
      for (int e = 10; e <= 19; e++) begin
         step();
         if (RESET_VIDEO !== 1'b1) ok = 1'b0;
      end
      chk("hold_drop_rv_held", int'(ok), 1);
      step();
      chk("hold_drop_rv_e20", int'(RESET_VIDEO), 0);
      repeat (4) step();
      chk("hold_drop_ready_e24", int'(READY), 1);
      chk("hold_drop_loss", int'(LOSS_COUNT), 2);

      // Short button bounce is filtered out.
      BTN_RESET = 1'b1;
      repeat (3) step();
      BTN_RESET = 1'b0;
      ok = 1'b1;
      repeat (12) begin
         step();
         if (READY !== 1'b1 || RESET_VIDEO !== 1'b0) ok = 1'b0;
      end
      chk("bounce_no_change", int'(ok), 1);

      // Held button: resets on edge 7, no loss counted, re-release after debounce.
      BTN_RESET = 1'b1;
      repeat (6) step();
      chk("btn_ready_e6", int'(READY), 1);
      step();
      chk("btn_ready_e7", int'(READY), 0);
      chk("btn_rv_e7", int'(RESET_VIDEO), 1);
      chk("btn_cpu_e7", int'(RESET_CPU), 1);
      chk("btn_loss", int'(LOSS_COUNT), 2);
      repeat (3) step();
      BTN_RESET = 1'b0;
      repeat (14) step();
      chk("btn_rv_e24", int'(RESET_VIDEO), 1);
      step();
      chk("btn_rv_e25", int'(RESET_VIDEO), 0);
      repeat (3) step();
      chk("btn_ready_e28", int'(READY), 0);
      step();
      chk("btn_ready_e29", int'(READY), 1);

      // Simultaneous lock loss and button press counts once.
      loss_before = int'(LOSS_COUNT);
      LOCKED    = 1'b0;
      BTN_RESET = 1'b1;
      repeat (10) step();
      chk("both_loss_once", int'(LOSS_COUNT), loss_before + 1);
      LOCKED    = 1'b1;
      BTN_RESET = 1'b0;
      repeat (32) step();
      chk("both_ready_again", int'(READY), 1);
      chk("both_loss_stable", int'(LOSS_COUNT), 3);

      // Saturation of the loss counter.
      for (int i = 0; i < 260; i++) begin
         LOCKED = 1'b0;
         repeat (3) step();
         LOCKED = 1'b1;
         repeat (15) step();
         if (i == 99) chk("sat_loss_mid", int'(LOSS_COUNT), 103);
      end
      chk("sat_loss_255", int'(LOSS_COUNT), 255);
      chk("sat_ready", int'(READY), 1);

      // Asynchronous reset in the middle of the video-release gap.
      LOCKED = 1'b0;
      repeat (3) step();
      LOCKED = 1'b1;
      repeat (12) step();
      chk("arst_pre_rv", int'(RESET_VIDEO), 0);
      chk("arst_pre_ready", int'(READY), 0);
      #2;
      RESET = 1'b1;
      #1;
      chk("arst_rv", int'(RESET_VIDEO), 1);
      chk("arst_cpu", int'(RESET_CPU), 1);
      chk("arst_ready", int'(READY), 0);
      chk("arst_loss", int'(LOSS_COUNT), 0);
      step();
      RESET = 1'b0;
      check_release("arst");
      chk("arst_final_loss", int'(LOSS_COUNT), 0);

      step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
